// File: rtl/pwm_multi.sv
// N-channel PWM generator with one shared prescaler and one period counter.
// Each channel's duty is shadowed and goes active at a period boundary.
module pwm_multi #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8,
  parameter int DIV_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [DIV_W-1:0]        div,
  input  logic [CNT_W-1:0]        period,
  input  logic                    center,
  input  logic [CNT_W-1:0]        duty_in,
  input  logic [N_CH-1:0]         duty_wr,
  input  logic [N_CH-1:0]         duty_inc,
  input  logic [N_CH-1:0]         duty_dec,
  input  logic [CNT_W-1:0]        step,
  input  logic [N_CH-1:0]         invert,
  output logic [N_CH-1:0]         pwm_out,
  output logic                    period_start,
  output logic [N_CH*CNT_W-1:0]   duty_active
);

  localparam logic [CNT_W-1:0] DUTY_RST = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  logic [DIV_W-1:0] r_pre;
  logic [DIV_W-1:0] r_div_l;
  logic [CNT_W-1:0] r_cnt;
  dir_t             r_dir;
  logic             r_first;
  logic [CNT_W-1:0] r_period_l;
  logic             r_center_l;
  logic [CNT_W-1:0] r_shadow [N_CH];
  logic [CNT_W-1:0] r_active [N_CH];
  logic [N_CH-1:0]  r_pwm;
  logic             r_ps;

  logic             w_tick;
  logic             w_going_down;
  logic             w_bound_e;
  logic             w_bound_c;
  logic             w_boundary;
  logic [CNT_W-1:0] w_cnt_nxt;
  dir_t             w_dir_nxt;
  logic [N_CH-1:0]  w_raw;
  logic [CNT_W:0]   w_sum [N_CH];
  logic [CNT_W:0]   w_dif [N_CH];
  logic [CNT_W-1:0] w_shadow_nxt [N_CH];

  // The divide value is only re-latched at a wrap, so a change never strands r_pre above it.
  assign w_tick = en && (r_pre == r_div_l);

  // r_first marks the first tick after enable, which always starts a fresh period.
  always_comb begin
    w_going_down = (r_dir == DIR_DOWN) || (r_cnt >= r_period_l);
    w_bound_e    = (r_period_l == '0) || (r_cnt >= r_period_l);
    w_bound_c    = (r_period_l == '0) || (w_going_down && (r_cnt <= CNT_W'(1)));
    w_boundary   = w_tick && (r_first || (r_center_l ? w_bound_c : w_bound_e));
    w_cnt_nxt    = r_cnt;
    w_dir_nxt    = r_dir;
    if (w_boundary) begin
      w_cnt_nxt = '0;
      w_dir_nxt = DIR_UP;
    end else if (!r_center_l) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end else if (w_going_down) begin
      w_cnt_nxt = r_cnt - CNT_W'(1);
      w_dir_nxt = DIR_DOWN;
    end else begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
      w_dir_nxt = DIR_UP;
    end
  end

  // Shadow next value: a write beats a step; inc and dec together cancel.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      w_sum[i]        = {1'b0, r_shadow[i]} + {1'b0, step};
      w_dif[i]        = {1'b0, r_shadow[i]} - {1'b0, step};
      w_shadow_nxt[i] = r_shadow[i];
      if (duty_wr[i]) begin
        w_shadow_nxt[i] = duty_in;
      end else if (w_tick && duty_inc[i] && !duty_dec[i]) begin
        w_shadow_nxt[i] = w_sum[i][CNT_W] ? CNT_MAX : w_sum[i][CNT_W-1:0];
      end else if (w_tick && duty_dec[i] && !duty_inc[i]) begin
        w_shadow_nxt[i] = w_dif[i][CNT_W] ? '0 : w_dif[i][CNT_W-1:0];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      w_raw[i] = (r_cnt < r_active[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre      <= '0;
      r_div_l    <= '0;
      r_cnt      <= '0;
      r_dir      <= DIR_UP;
      r_first    <= 1'b0;
      r_period_l <= CNT_MAX;
      r_center_l <= 1'b0;
      r_pwm      <= '0;
      r_ps       <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        r_shadow[i] <= DUTY_RST;
        r_active[i] <= DUTY_RST;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        r_shadow[i] <= w_shadow_nxt[i];
      end
      if (!en) begin
        r_pre   <= '0;
        r_div_l <= div;
        r_cnt   <= '0;
        r_dir   <= DIR_UP;
        r_first <= 1'b1;
        r_pwm   <= invert;
        r_ps    <= 1'b0;
      end else begin
        r_pwm <= w_raw ^ invert;
        r_ps  <= w_boundary;
        if (w_tick) begin
          r_pre   <= '0;
          r_div_l <= div;
          r_cnt   <= w_cnt_nxt;
          r_dir   <= w_dir_nxt;
          if (w_boundary) begin
            r_first    <= 1'b0;
            r_period_l <= period;
            r_center_l <= center;
            for (int i = 0; i < N_CH; i++) begin
              r_active[i] <= r_shadow[i];
            end
          end
        end else begin
          r_pre <= r_pre + DIV_W'(1);
        end
      end
    end
  end

  assign pwm_out      = r_pwm;
  assign period_start = r_ps;

  for (genvar g = 0; g < N_CH; g++) begin : g_act
    assign duty_active[g*CNT_W +: CNT_W] = r_active[g];
  end

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
Parameterised N-channel PWM generator that replaces the single-channel 3-bit PWM block. It uses one shared prescaler and one period counter. Each channel has its own duty value, held in a shadow register and loaded into the active register at each period boundary. Supports edge- and center-aligned modes, saturating step inc/dec, and per-channel polarity. It sits between the register/control interface and the heater/driver output pins.

Parameters:
N_CH, 4, number of PWM channels
CNT_W, 8, width of period counter, period and duty values
DIV_W, 4, width of prescaler divide value

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
en  input  1  global enable; low forces outputs inactive and clears counters
div  input  DIV_W  prescale: one tick every div+1 clk cycles (div=0 -> every cycle)
period  input  CNT_W  terminal count; latched at period boundary
center  input  1  0 = edge-aligned, 1 = center-aligned; latched at period boundary
duty_in  input  CNT_W  shared duty write data
duty_wr  input  N_CH  per-channel write strobe for duty_in into shadow
duty_inc  input  N_CH  per-channel increment-by-step request (sampled on tick)
duty_dec  input  N_CH  per-channel decrement-by-step request (sampled on tick)
step  input  CNT_W  inc/dec step size
invert  input  N_CH  per-channel output polarity (1 = active-low)
pwm_out  output  N_CH  registered PWM outputs
period_start  output  1  one-clk pulse on the tick where a new period begins
duty_active  output  N_CH*CNT_W  currently active duty per channel, ch0 in LSBs

Behaviour:
- Reset values:
  - prescaler=0, cnt=0, dir=up.
  - shadow duty and active duty = 2^(CNT_W-1) (50% at period=2^CNT_W-1).
  - period_l=2^CNT_W-1, center_l=0.
  - pwm_out = invert-independent 0, period_start=0.
- Prescaler: counts 0..div on every clk while en=1. tick=1 on the cycle it equals div, then it wraps to 0. A div change takes effect at the next wrap.
- Edge mode counter: cnt increments each tick. When cnt==period_l it wraps to 0 and that tick is the boundary. Period = period_l+1 ticks.
- Center mode counter: cnt counts up to period_l, dir flips to down, counts to 0, dir flips to up. Boundary is the tick where cnt returns to 0. Period = 2*period_l ticks.
- period_l==0 in either mode: cnt stays 0 and every tick is a boundary.
- On each boundary tick:
  - active duty <= shadow for all channels; period_l <= period; center_l <= center.
  - period_start pulses for 1 clk.
  - On entering center mode, dir is set to up.
- Channel raw level = (cnt < duty_active). It is registered, so pwm_out changes 1 clk after the tick that moved cnt.
- Output value: pwm_out = raw XOR invert.
- Duty extremes:
  - duty_active=0 gives constant raw 0.
  - duty_active > period_l gives constant raw 1 (100%).
- Shadow update priority, per channel, per clk:
  1. duty_wr (any clk, not tick-gated) writes duty_in.
  2. Otherwise on tick: inc alone adds step, saturating at 2^CNT_W-1; dec alone subtracts step, saturating at 0.
  3. inc and dec together: no change.
- Arithmetic: sums are computed CNT_W+1 wide to detect saturation; no wrap-around is permitted.
- en=0:
  - prescaler, cnt and dir are cleared; pwm_out = invert (inactive level); period_start=0.
  - Shadow and active duty are retained; duty_wr is still accepted.
- en rising: the first tick arrives div+1 clks later. That tick is a boundary, so pending shadow values load.
- rst mid-period: everything returns to reset values immediately (async). The first post-reset boundary follows the normal count.
- duty_active reflects active registers, not shadows.

Test Plan:
1. Reset, en=1, div=0, period=7, duty_wr ch0 with 3 -> from 2nd boundary ch0 high 3 clks, low 5, period_start every 8 clks.
2. div=3, period=3, ch1 duty=2 -> tick every 4 clks; ch1 high 8 clks, low 8; change of div mid-run applies at prescaler wrap.
3. center=1, period=4, ch2 duty=2 -> 8-tick period; high when cnt in {0,1} on both up and down slopes; symmetric about cnt=4.
4. ch0 shadow=250, step=10, duty_inc held 2 ticks -> shadow 255 (saturated). Then dec with step=200 twice -> 55, then 0. inc+dec together -> unchanged. duty_wr concurrent with inc -> duty_in wins.
5. Write duty mid-period -> pwm_out unchanged until next period_start; duty_active updates on that boundary. Duty 0 -> constant low; duty 9 with period 7 -> constant high; invert=1 -> complementary.
6. Drop en mid-period -> pwm_out = invert next clk, counters 0. Re-enable -> first period_start after div+1 clks. Assert rst mid-period -> all outputs 0 and duty_active=128 immediately.
